// File: rtl/gmux_pkg.sv
// Shared types and helpers for the GMUX select sequencer.
package gmux_pkg;

    // Switch sequencer states; BUSY is simply "state != SW_IDLE".
    typedef enum logic [2:0] {
        SW_IDLE      = 3'd0,
        SW_GATE_OFF  = 3'd1,
        SW_WAIT_PRE  = 3'd2,
        SW_FLIP      = 3'd3,
        SW_WAIT_POST = 3'd4,
        SW_FIN       = 3'd5
    } gmux_sw_state_t;

    // GMUX select encoding (IS0 bit value).
    localparam logic GMUX_MODE_IP = 1'b0;
    localparam logic GMUX_MODE_IC = 1'b1;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int gmux_ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/gmux_guard_timer.sv
// Guard-interval down-counter: load to GUARD, count down, saturate at zero.
module gmux_guard_timer #(
    parameter int  GUARD = 3,
    localparam int CW    = (GUARD > 0) ? $clog2(GUARD + 1) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero,
    output logic last
);

    localparam logic [CW-1:0] GUARD_V = CW'(GUARD);

    logic [CW-1:0] cnt_q;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= GUARD_V;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // "last" marks the final cycle of a guard interval.
    assign zero = (cnt_q == '0);
    assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/gmux_switch_ctrl.sv
// Sequenced select controller for a bank of GMUX channels.
// A switch closes the channel gate, waits GUARD cycles, flips IS0, waits
// GUARD cycles, then reopens the gate, so the downstream output never sees
// a runt pulse while the mux select moves.
module gmux_switch_ctrl
    import gmux_pkg::*;
#(
    parameter int              N_CH      = 4,
    parameter int              GUARD     = 3,
    parameter logic [N_CH-1:0] RESET_SEL = '0,
    localparam int             CHW       = gmux_ch_width(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high. The source holds req_ch/req_sel stable while
    // req_valid is high and not yet accepted; nothing is dropped or queued.
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [CHW-1:0]  req_ch,
    input  logic            req_sel,
    output logic [N_CH-1:0] is0,
    output logic [N_CH-1:0] gate_en,
    output logic            busy,
    output logic            done,
    output logic            err,
    output gmux_sw_state_t  state_dbg
);

    localparam logic [CHW:0] N_CH_V = (CHW + 1)'(N_CH);

    gmux_sw_state_t  state_q, state_d;
    logic [CHW-1:0]  ch_q;
    logic            sel_q;
    logic [N_CH-1:0] is0_q;
    logic [N_CH-1:0] gate_q;
    logic            done_q;
    logic            err_q;

    logic [N_CH-1:0] req_mask;
    logic [N_CH-1:0] ch_mask;
    logic            cur_sel;
    logic            req_bad;
    logic            accept;

    logic            tmr_load;
    logic            tmr_zero;
    logic            tmr_last;
    logic            do_start;
    logic            do_flip;
    logic            do_finish;
    logic            do_noop;
    logic            do_bad;

    gmux_guard_timer #(
        .GUARD (GUARD)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .zero  (tmr_zero),
        .last  (tmr_last)
    );

    // Ready only in IDLE and not in a DONE/ERR pulse cycle.
    assign req_ready = (state_q == SW_IDLE) && !done_q && !err_q;
    assign accept    = req_valid && req_ready;
    assign req_bad   = ({1'b0, req_ch} >= N_CH_V);

    // Decode requested and latched channel into one-hot masks.
    always_comb begin
        req_mask = '0;
        ch_mask  = '0;
        cur_sel  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (req_ch == CHW'(i)) begin
                req_mask[i] = 1'b1;
                cur_sel     = is0_q[i];
            end
            if (ch_q == CHW'(i)) begin
                ch_mask[i] = 1'b1;
            end
        end
    end

    // Next-state and per-step strobes for the switch sequence.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        do_start  = 1'b0;
        do_flip   = 1'b0;
        do_finish = 1'b0;
        do_noop   = 1'b0;
        do_bad    = 1'b0;
        case (state_q)
            SW_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        do_bad = 1'b1;
                    end else if (req_sel == cur_sel) begin
                        do_noop = 1'b1;
                    end else begin
                        do_start = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = SW_GATE_OFF;
                    end
                end
            end
            SW_GATE_OFF, SW_WAIT_PRE: begin
                if (tmr_last || tmr_zero) begin
                    do_flip  = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = SW_FLIP;
                end else begin
                    state_d = SW_WAIT_PRE;
                end
            end
            SW_FLIP, SW_WAIT_POST: begin
                if (tmr_last || tmr_zero) begin
                    do_finish = 1'b1;
                    state_d   = SW_FIN;
                end else begin
                    state_d = SW_WAIT_POST;
                end
            end
            SW_FIN: begin
                state_d = SW_IDLE;
            end
            default: begin
                state_d = SW_IDLE;
            end
        endcase
    end

    // State, latched request and the registered GMUX outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SW_IDLE;
            ch_q    <= '0;
            sel_q   <= 1'b0;
            is0_q   <= RESET_SEL;
            gate_q  <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= do_noop || do_finish;
            err_q   <= do_bad;
            if (do_start) begin
                ch_q   <= req_ch;
                sel_q  <= req_sel;
                gate_q <= gate_q & ~req_mask;
            end
            if (do_flip) begin
                is0_q <= (is0_q & ~ch_mask) | ((sel_q == GMUX_MODE_IC) ? ch_mask : '0);
            end
            if (do_finish) begin
                gate_q <= gate_q | ch_mask;
            end
        end
    end

    assign is0       = is0_q;
    assign gate_en   = gate_q;
    assign busy      = (state_q != SW_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_gmux_switch_ctrl.sv
// Bench for gmux_switch_ctrl: timeline model plus directed literal checks.
module tb_gmux_switch_ctrl;
    import gmux_pkg::*;

    localparam int         N   = 4;
    localparam int         G   = 3;
    localparam logic [3:0] RS  = 4'b0101;
    localparam int         N5  = 5;
    localparam int         G5  = 1;
    localparam logic [4:0] RS5 = 5'b00101;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (4 channels, GUARD=3) ----------------
    logic           req_valid = 1'b0;
    logic [1:0]     req_ch    = '0;
    logic           req_sel   = 1'b0;
    logic           req_ready;
    logic [3:0]     is0, gate_en;
    logic           busy, done, err;
    gmux_sw_state_t state_dbg;

    gmux_switch_ctrl #(.N_CH(N), .GUARD(G), .RESET_SEL(RS)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_sel(req_sel), .is0(is0), .gate_en(gate_en),
        .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- DUT (5 channels, GUARD=1): bad index, min guard ----------------
    logic           v5_valid = 1'b0;
    logic [2:0]     v5_ch    = '0;
    logic           v5_sel   = 1'b0;
    logic           v5_ready;
    logic [4:0]     v5_is0, v5_gate;
    logic           v5_busy, v5_done, v5_err;
    gmux_sw_state_t v5_state;

    gmux_switch_ctrl #(.N_CH(N5), .GUARD(G5), .RESET_SEL(RS5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .req_valid(v5_valid), .req_ready(v5_ready),
        .req_ch(v5_ch), .req_sel(v5_sel), .is0(v5_is0), .gate_en(v5_gate),
        .busy(v5_busy), .done(v5_done), .err(v5_err), .state_dbg(v5_state)
    );

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks committed IS0 plus an in-flight switch as "cycles since accept";
    // every output follows from that age and the documented timeline.
    logic [3:0] m_is0    = RS;
    bit         m_active = 1'b0;
    int         m_d      = 0;
    int         m_ch     = 0;
    bit         m_sel    = 1'b0;
    bit         m_done   = 1'b0;
    bit         m_err    = 1'b0;

    function automatic logic [3:0] exp_gate();
        logic [3:0] g;
        g = 4'hF;
        if (m_active && m_d <= 2 * G) g[m_ch] = 1'b0;
        return g;
    endfunction

    function automatic logic [3:0] exp_is0();
        logic [3:0] v;
        v = m_is0;
        if (m_active && m_d >= G + 1) v[m_ch] = m_sel;
        return v;
    endfunction

    function automatic bit exp_done();
        return m_active ? (m_d == 2 * G + 1) : m_done;
    endfunction

    function automatic bit exp_ready();
        return !m_active && !m_done && !m_err;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit rdy;
        if (!rst_n) begin
            m_is0    = RS;
            m_active = 1'b0;
            m_d      = 0;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end else begin
            rdy    = exp_ready();
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_active) begin
                m_d++;
                if (m_d == 2 * G + 2) begin
                    m_is0[m_ch] = m_sel;
                    m_active    = 1'b0;
                end
            end else if (rdy && req_valid) begin
                if (int'(req_ch) >= N) begin
                    m_err = 1'b1;
                end else if (req_sel == m_is0[req_ch]) begin
                    m_done = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_d      = 1;
                    m_ch     = int'(req_ch);
                    m_sel    = req_sel;
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("m_is0",   32'(is0),       32'(exp_is0()));
        chk("m_gate",  32'(gate_en),   32'(exp_gate()));
        chk("m_busy",  32'(busy),      32'(m_active));
        chk("m_done",  32'(done),      32'(exp_done()));
        chk("m_err",   32'(err),       32'(m_active ? 1'b0 : m_err));
        chk("m_ready", 32'(req_ready), 32'(exp_ready()));
        chk("m_excl",  32'(done & err), 32'(0));
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] ch, input logic sel);
        @(posedge clk); #1;
        req_valid = 1'b1; req_ch = ch; req_sel = sel;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic issue5(input logic [2:0] ch, input logic sel);
        @(posedge clk); #1;
        v5_valid = 1'b1; v5_ch = ch; v5_sel = sel;
        @(posedge clk); #1;
        v5_valid = 1'b0;
    endtask

    // Literal GUARD=3 timeline for a switch accepted just before this call's first cycle.
    task automatic check_switch(input string tag, input logic [3:0] g_low,
                                input logic [3:0] s_before, input logic [3:0] s_after);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk({tag, "_gate"},  32'(gate_en),   32'((k <= 6) ? g_low : 4'hF));
            chk({tag, "_is0"},   32'(is0),       32'((k >= 4) ? s_after : s_before));
            chk({tag, "_done"},  32'(done),      32'(k == 7));
            chk({tag, "_busy"},  32'(busy),      32'(k <= 7));
            chk({tag, "_ready"}, 32'(req_ready), 32'(k == 8));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_is0",   32'(is0),       32'(4'b0101));
        chk("rst_gate",  32'(gate_en),   32'(4'b1111));
        chk("rst_ready", 32'(req_ready), 32'(1));
        chk("rst_done",  32'(done),      32'(0));
        chk("rst_err",   32'(err),       32'(0));
        chk("rst_busy",  32'(busy),      32'(0));
        chk("rst_is0_5", 32'(v5_is0),    32'(5'b00101));
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // ch1 IP->IC, then ch2 IC->IP, then ch2 IP->IC
        issue(2'd1, 1'b1);
        check_switch("sw_ch1", 4'b1101, 4'b0101, 4'b0111);
        issue(2'd2, 1'b0);
        check_switch("sw_ch2_ip", 4'b1011, 4'b0111, 4'b0011);
        issue(2'd2, 1'b1);
        check_switch("sw_ch2_ic", 4'b1011, 4'b0011, 4'b0111);

        // no-op: ch0 already IC
        issue(2'd0, 1'b1);
        @(negedge clk);
        chk("noop_done",  32'(done),      32'(1));
        chk("noop_busy",  32'(busy),      32'(0));
        chk("noop_gate",  32'(gate_en),   32'(4'b1111));
        chk("noop_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        chk("noop_done2", 32'(done),      32'(0));
        chk("noop_rdy2",  32'(req_ready), 32'(1));

        // back-to-back: ch3->IC, then ch0->IP held during the first
        @(posedge clk); #1;
        req_valid = 1'b1; req_ch = 2'd3; req_sel = 1'b1;
        @(posedge clk); #1;
        req_ch = 2'd0; req_sel = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(req_ready), 32'(k == 8));
            chk("b2b_busy",  32'(busy),      32'(k <= 7));
            chk("b2b_gate",  32'(gate_en),   32'((k <= 6) ? 4'b0111 : 4'b1111));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_gate2", 32'(gate_en), 32'(4'b1110));
        chk("b2b_busy2", 32'(busy),    32'(1));
        repeat (7) @(negedge clk);
        chk("b2b_is0",   32'(is0),       32'(4'b1110));
        chk("b2b_rdy3",  32'(req_ready), 32'(1));

        // reset in the middle of a switch (ch0 -> IC), at t+4
        issue(2'd0, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        chk("mid_flip", 32'(is0), 32'(4'b1111));
        rst_n = 1'b0;
        #1;
        chk("mid_is0",   32'(is0),       32'(4'b0101));
        chk("mid_gate",  32'(gate_en),   32'(4'b1111));
        chk("mid_busy",  32'(busy),      32'(0));
        chk("mid_ready", 32'(req_ready), 32'(1));
        chk("mid_state", 32'(state_dbg), 32'(SW_IDLE));
        @(posedge clk); #2;
        rst_n = 1'b1;
        issue(2'd3, 1'b1);
        check_switch("post_rst", 4'b0111, 4'b0101, 4'b1101);

        // 5-channel instance: bad index, no-op, GUARD=1 switch
        issue5(3'd5, 1'b1);
        @(negedge clk);
        chk("bad_err",   32'(v5_err),   32'(1));
        chk("bad_done",  32'(v5_done),  32'(0));
        chk("bad_ready", 32'(v5_ready), 32'(0));
        chk("bad_is0",   32'(v5_is0),   32'(5'b00101));
        chk("bad_gate",  32'(v5_gate),  32'(5'b11111));
        chk("bad_busy",  32'(v5_busy),  32'(0));
        @(negedge clk);
        chk("bad_err2",  32'(v5_err),   32'(0));
        chk("bad_rdy2",  32'(v5_ready), 32'(1));
        issue5(3'd7, 1'b0);
        @(negedge clk);
        chk("bad7_err",  32'(v5_err),   32'(1));
        issue5(3'd4, 1'b0);
        @(negedge clk);
        chk("n4_done",   32'(v5_done),  32'(1));
        chk("n4_err",    32'(v5_err),   32'(0));
        issue5(3'd1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("g1_gate",  32'(v5_gate),  32'((k <= 2) ? 5'b11101 : 5'b11111));
            chk("g1_is0",   32'(v5_is0),   32'((k >= 2) ? 5'b00111 : 5'b00101));
            chk("g1_done",  32'(v5_done),  32'(k == 3));
            chk("g1_ready", 32'(v5_ready), 32'(k == 4));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
